// File: rtl/mt_thread_sched.sv
// ============================================================================
// mt_thread_sched : parity-interleaved round-robin thread scheduler with
//                   writeback tracking and drained thread-group switching.
// Optional feature macro: SCHED_STALL_CNT_EN (adds 16-bit stall_cnt output).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mt_thread_sched #(
    parameter int NUM_THREADS  = 4,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int WB_LAT       = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_THREADS-1:0]  thread_ready,
    input  logic                    wb_we,
    input  logic                    grp_switch_req,
    output logic                    issue_valid,
    output logic [BITS_THREADS-1:0] tid_read,
    output logic [BITS_THREADS-1:0] tid_write,
    output logic                    write_enable,
    output logic                    tgrp,
    output logic                    grp_switch_ack
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int c_NCLS  = NUM_THREADS / 2;
    localparam int c_CLS_W = (c_NCLS > 1) ? $clog2(c_NCLS) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_par;
    logic                    r_tgrp;
    logic [c_CLS_W-1:0]      r_ptr_even;
    logic [c_CLS_W-1:0]      r_ptr_odd;
    logic [BITS_THREADS-1:0] r_tid_last;
    logic [WB_LAT-1:0]       r_pv;
    logic [BITS_THREADS-1:0] r_pt [WB_LAT];

    logic [c_CLS_W-1:0]      w_ptr;
    logic [c_CLS_W-1:0]      w_cand;
    logic [BITS_THREADS-1:0] w_cand_tid;
    logic [c_CLS_W-1:0]      w_sel_idx;
    logic [c_CLS_W-1:0]      w_ptr_nxt;
    logic [BITS_THREADS-1:0] w_sel_tid;
    logic                    w_found;
    logic                    w_issue;
    logic [BITS_THREADS-1:0] w_tid_rd;
    logic                    w_ack;

    // Pointers hold the class index where the next search starts (one past
    // the last issued thread), so a reset pointer selects thread 0 first.
    always_comb begin
        w_found    = 1'b0;
        w_sel_idx  = '0;
        w_cand     = '0;
        w_cand_tid = '0;
        w_ptr      = r_par ? r_ptr_odd : r_ptr_even;
        for (int k = 0; k < c_NCLS; k++) begin
            w_cand     = (c_NCLS == 1) ? '0 : w_ptr + c_CLS_W'(k);
            w_cand_tid = BITS_THREADS'({w_cand, r_par});
            if (!w_found && thread_ready[w_cand_tid]) begin
                w_found   = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    assign w_sel_tid = BITS_THREADS'({w_sel_idx, r_par});
    assign w_ptr_nxt = (c_NCLS == 1) ? '0 : w_sel_idx + c_CLS_W'(1);
    assign w_issue   = (r_state == S_RUN) && w_found;
    assign w_tid_rd  = w_issue ? w_sel_tid : r_tid_last;

    // Output gating keeps the reset-state RUN from advertising an issue.
    assign issue_valid    = w_issue & rst_n;
    assign tid_read       = issue_valid ? w_sel_tid : r_tid_last;
    assign tid_write      = r_pt[WB_LAT-1];
    assign write_enable   = r_pv[WB_LAT-1] & wb_we;
    assign tgrp           = r_tgrp;
    assign grp_switch_ack = w_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        case (r_state)
            S_RUN:    if (grp_switch_req) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_pv == '0) w_state_nxt = S_SWITCH;
            S_SWITCH: begin
                w_ack       = 1'b1;
                w_state_nxt = S_RUN;
            end
            default:  w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_par      <= 1'b0;
            r_tgrp     <= 1'b0;
            r_ptr_even <= '0;
            r_ptr_odd  <= '0;
            r_tid_last <= '0;
            r_pv       <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                r_pt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_par   <= ~r_par;
            if (r_state == S_SWITCH) begin
                r_tgrp     <= ~r_tgrp;
                r_ptr_even <= '0;
                r_ptr_odd  <= '0;
            end else if (w_issue) begin
                r_tid_last <= w_sel_tid;
                if (r_par) r_ptr_odd  <= w_ptr_nxt;
                else       r_ptr_even <= w_ptr_nxt;
            end
            // Odd depth guarantees the tail parity is opposite the issue parity.
            r_pv[0] <= w_issue;
            r_pt[0] <= w_tid_rd;
            for (int i = 1; i < WB_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_SWITCH) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !w_issue && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mt_thread_sched.sv
// ============================================================================
// tb_mt_thread_sched : directed + random self-checking bench for mt_thread_sched
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mt_thread_sched;

    localparam int NT = 4;
    localparam int BT = 2;
    localparam int WL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NT-1:0] thread_ready = '0;
    logic          wb_we = 1'b0;
    logic          grp_switch_req = 1'b0;
    logic          issue_valid;
    logic [BT-1:0] tid_read;
    logic [BT-1:0] tid_write;
    logic          write_enable;
    logic          tgrp;
    logic          grp_switch_ack;
`ifdef SCHED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    mt_thread_sched #(
        .NUM_THREADS (NT),
        .BITS_THREADS(BT),
        .WB_LAT      (WL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .thread_ready  (thread_ready),
        .wb_we         (wb_we),
        .grp_switch_req(grp_switch_req),
        .issue_valid   (issue_valid),
        .tid_read      (tid_read),
        .tid_write     (tid_write),
        .write_enable  (write_enable),
        .tgrp          (tgrp),
        .grp_switch_ack(grp_switch_ack)
`ifdef SCHED_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [BT-1:0] tid;
    } wb_t;

    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model: last-issued thread per parity class, search steps by 2.
    int  m_state;
    bit  m_par;
    int  m_last [2];
    int  m_prev;
    bit  m_tgrp;
    int  m_stall;
    wb_t q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_par     = 1'b0;
        m_last[0] = NT - 2;
        m_last[1] = NT - 1;
        m_prev    = 0;
        m_tgrp    = 1'b0;
        m_stall   = 0;
        q.delete();
        for (int i = 0; i < WL; i++) q.push_back('0);
    endtask

    task automatic cyc(input logic r, input logic [NT-1:0] rdy, input logic we, input logic req);
        logic e_iv;
        int   e_tid;
        int   t;
        bit   drained;
        wb_t  tail;
        @(posedge clk);
        #1;
        rst_n          = r;
        thread_ready   = rdy;
        wb_we          = we;
        grp_switch_req = req;
        #4;
        if (!r) begin
            model_reset();
            chk("rst_issue_valid", 32'(issue_valid), 0);
            chk("rst_write_enable", 32'(write_enable), 0);
            chk("rst_ack", 32'(grp_switch_ack), 0);
            chk("rst_tgrp", 32'(tgrp), 0);
            chk("rst_tid_write", 32'(tid_write), 0);
            chk("rst_tid_read", 32'(tid_read), 0);
`ifdef SCHED_STALL_CNT_EN
            chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
            return;
        end
        e_iv  = 1'b0;
        e_tid = m_prev;
        if (m_state == 0) begin
            for (int k = 1; k <= NT / 2; k++) begin
                t = (m_last[m_par] + 2 * k) % NT;
                if (!e_iv && rdy[t]) begin
                    e_iv  = 1'b1;
                    e_tid = t;
                end
            end
        end
        chk("issue_valid", 32'(issue_valid), 32'(e_iv));
        chk("tid_read", 32'(tid_read), 32'(e_tid));
        chk("grp_switch_ack", 32'(grp_switch_ack), 32'(m_state == 2));
        chk("tgrp", 32'(tgrp), 32'(m_tgrp));
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        drained = 1'b1;
        foreach (q[i]) if (q[i].v) drained = 1'b0;
        tail = q.pop_front();
        chk("write_enable", 32'(write_enable), 32'(tail.v & we));
        if (tail.v) chk("tid_write", 32'(tid_write), 32'(tail.tid));
        if (issue_valid && write_enable) chk("bank_parity", 32'(tid_write[0] ^ tid_read[0]), 1);
        q.push_back('{v: e_iv, tid: BT'(e_tid)});
        if (e_iv) begin
            m_last[m_par] = e_tid;
            m_prev        = e_tid;
        end
        if (m_state == 0 && !e_iv && m_stall < 65535) m_stall++;
        case (m_state)
            0: if (req) m_state = 1;
            1: if (drained) m_state = 2;
            default: begin
                m_state   = 0;
                m_tgrp    = !m_tgrp;
                m_last[0] = NT - 2;
                m_last[1] = NT - 1;
                m_stall   = 0;
            end
        endcase
        m_par = !m_par;
    endtask

    initial begin
        model_reset();
        repeat (3) cyc(1'b0, 4'hF, 1'b0, 1'b0);
        // all ready: 0,1,2,3,... and writeback three cycles later
        repeat (8) cyc(1'b1, 4'hF, 1'b1, 1'b0);
        // even threads only: bubbles on odd parity cycles
        repeat (8) cyc(1'b1, 4'b0101, 1'b1, 1'b0);
        // single-cycle switch request in steady run
        repeat (3) cyc(1'b1, 4'hF, 1'b1, 1'b0);
        cyc(1'b1, 4'hF, 1'b1, 1'b1);
        repeat (10) cyc(1'b1, 4'hF, 1'b1, 1'b0);
        // odd threads only, then nothing ready
        repeat (4) cyc(1'b1, 4'b1010, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 4'b0000, 1'b1, 1'b0);
        // held request: back-to-back switches
        repeat (16) cyc(1'b1, 4'hF, 1'b1, 1'b1);
        repeat (4) cyc(1'b1, 4'hF, 1'b1, 1'b0);
        // reset in the middle of a drain
        cyc(1'b1, 4'hF, 1'b1, 1'b1);
        repeat (2) cyc(1'b1, 4'hF, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 4'hF, 1'b1, 1'b0);
        repeat (6) cyc(1'b1, 4'hF, 1'b1, 1'b0);
        // random traffic
        repeat (60) cyc(1'b1, NT'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
